tlb_ctrl: RTL

Sequencer for the 16-entry TLB: executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB issued at commit. Each op is accepted over a valid/ready handshake and drives the TLB write, read and invtlb ports. It borrows search port 1 from the MEM stage, stalling MEM while borrowed. Results return as CSR images (TLBIDX/TLBEHI/TLBELO0/TLBELO1/ASID) with a one-cycle response pulse.

---
 rtl/tlb_ctrl_if.sv | 89 ++++++++
 rtl/tlb_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tlb_ctrl_if.sv
// Commit-side op handshake, CSR images, MEM search request and TLB port bundle for tlb_ctrl.
interface tlb_ctrl_if #(parameter int TLBNUM = 16);
    localparam int IW = $clog2(TLBNUM);

    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [4:0]    inv_op;
    logic [9:0]    inv_asid;
    logic [18:0]   inv_vppn;
    logic [31:0]   csr_tlbidx;
    logic [31:0]   csr_tlbehi;
    logic [31:0]   csr_tlbelo0;
    logic [31:0]   csr_tlbelo1;
    logic [9:0]    csr_asid;

    logic [18:0]   mem_vppn;
    logic          mem_va_bit12;
    logic [9:0]    mem_asid;
    logic          mem_stall;

    logic [18:0]   tlb_s1_vppn;
    logic          tlb_s1_va_bit12;
    logic [9:0]    tlb_s1_asid;
    logic          tlb_s1_found;
    logic [IW-1:0] tlb_s1_index;

    logic          tlb_invtlb_valid;
    logic [4:0]    tlb_invtlb_op;

    logic          tlb_we;
    logic [IW-1:0] tlb_w_index;
    logic          tlb_w_e;
    logic [5:0]    tlb_w_ps;
    logic [18:0]   tlb_w_vppn;
    logic [9:0]    tlb_w_asid;
    logic          tlb_w_g;
    logic [19:0]   tlb_w_ppn0, tlb_w_ppn1;
    logic [1:0]    tlb_w_plv0, tlb_w_plv1;
    logic [1:0]    tlb_w_mat0, tlb_w_mat1;
    logic          tlb_w_d0, tlb_w_d1;
    logic          tlb_w_v0, tlb_w_v1;

    logic [IW-1:0] tlb_r_index;
    logic          tlb_r_e;
    logic [5:0]    tlb_r_ps;
    logic [18:0]   tlb_r_vppn;
    logic [9:0]    tlb_r_asid;
    logic          tlb_r_g;
    logic [19:0]   tlb_r_ppn0, tlb_r_ppn1;
    logic [1:0]    tlb_r_plv0, tlb_r_plv1;
    logic [1:0]    tlb_r_mat0, tlb_r_mat1;
    logic          tlb_r_d0, tlb_r_d1;
    logic          tlb_r_v0, tlb_r_v1;

    logic          rsp_valid;
    logic [2:0]    rsp_op;
    logic          rsp_err;
    logic [31:0]   res_tlbidx, res_tlbehi, res_tlbelo0, res_tlbelo1;
    logic [9:0]    res_asid;

    modport slave (
        input  op_valid, op_code, inv_op, inv_asid, inv_vppn,
               csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid,
               mem_vppn, mem_va_bit12, mem_asid, tlb_s1_found, tlb_s1_index,
               tlb_r_e, tlb_r_ps, tlb_r_vppn, tlb_r_asid, tlb_r_g, tlb_r_ppn0, tlb_r_ppn1,
               tlb_r_plv0, tlb_r_plv1, tlb_r_mat0, tlb_r_mat1, tlb_r_d0, tlb_r_d1, tlb_r_v0, tlb_r_v1,
        output op_ready, mem_stall, tlb_s1_vppn, tlb_s1_va_bit12, tlb_s1_asid,
               tlb_invtlb_valid, tlb_invtlb_op, tlb_we, tlb_w_index,
               tlb_w_e, tlb_w_ps, tlb_w_vppn, tlb_w_asid, tlb_w_g, tlb_w_ppn0, tlb_w_ppn1,
               tlb_w_plv0, tlb_w_plv1, tlb_w_mat0, tlb_w_mat1, tlb_w_d0, tlb_w_d1, tlb_w_v0, tlb_w_v1,
               tlb_r_index, rsp_valid, rsp_op, rsp_err,
               res_tlbidx, res_tlbehi, res_tlbelo0, res_tlbelo1, res_asid
    );

    modport master (
        output op_valid, op_code, inv_op, inv_asid, inv_vppn,
               csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid,
               mem_vppn, mem_va_bit12, mem_asid, tlb_s1_found, tlb_s1_index,
               tlb_r_e, tlb_r_ps, tlb_r_vppn, tlb_r_asid, tlb_r_g, tlb_r_ppn0, tlb_r_ppn1,
               tlb_r_plv0, tlb_r_plv1, tlb_r_mat0, tlb_r_mat1, tlb_r_d0, tlb_r_d1, tlb_r_v0, tlb_r_v1,
        input  op_ready, mem_stall, tlb_s1_vppn, tlb_s1_va_bit12, tlb_s1_asid,
               tlb_invtlb_valid, tlb_invtlb_op, tlb_we, tlb_w_index,
               tlb_w_e, tlb_w_ps, tlb_w_vppn, tlb_w_asid, tlb_w_g, tlb_w_ppn0, tlb_w_ppn1,
               tlb_w_plv0, tlb_w_plv1, tlb_w_mat0, tlb_w_mat1, tlb_w_d0, tlb_w_d1, tlb_w_v0, tlb_w_v1,
               tlb_r_index, rsp_valid, rsp_op, rsp_err,
               res_tlbidx, res_tlbehi, res_tlbelo0, res_tlbelo1, res_asid
    );
endinterface

// File: rtl/tlb_ctrl.sv
// TLB op sequencer: SRCH/RD/WR/FILL/INV issued at commit, results returned as CSR images.
// Latency: work cycle at T+1, rsp_valid at T+2 (reserved ops: rsp at T+1).
// Backpressure: op_ready only in IDLE; MEM stage stalled while search port 1 is borrowed.
module tlb_ctrl #(
    parameter int TLBNUM = 16
) (
    input logic       clk,
    input logic       resetn,
    tlb_ctrl_if.slave bus
);
    localparam int IW = $clog2(TLBNUM);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [2:0] {IDLE, SRCH, RD, WRITE, INV, RESP} state_t;

    state_t        state, state_nxt;
    logic          accept;
    logic [IW-1:0] fill_cnt;

    logic [2:0]    op_q;
    logic          err_q;
    logic [4:0]    inv_op_q;
    logic [9:0]    inv_asid_q;
    logic [18:0]   inv_vppn_q;
    logic          ne_q;
    logic [5:0]    ps_q;
    logic [IW-1:0] index_q;
    logic [18:0]   vppn_q;
    logic [27:0]   elo0_q, elo1_q;
    logic [9:0]    asid_q;
    logic [IW-1:0] fill_q;

    logic [31:0]   res_tlbidx_q, res_tlbehi_q, res_tlbelo0_q, res_tlbelo1_q;
    logic [9:0]    res_asid_q;

    assign accept = bus.op_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        bus.op_ready         = 1'b0;
        bus.mem_stall        = 1'b0;
        bus.tlb_we           = 1'b0;
        bus.tlb_invtlb_valid = 1'b0;
        bus.rsp_valid        = 1'b0;
        bus.rsp_err          = 1'b0;
        case (state)
            IDLE: begin
                bus.op_ready = 1'b1;
                if (bus.op_valid) begin
                    case (bus.op_code)
                        OP_SRCH: state_nxt = SRCH;
                        OP_RD:   state_nxt = RD;
                        OP_WR,
                        OP_FILL: state_nxt = WRITE;
                        OP_INV:  state_nxt = INV;
                        default: state_nxt = RESP;
                    endcase
                end
            end
            SRCH: begin
                bus.mem_stall = 1'b1;
                state_nxt     = RESP;
            end
            RD: state_nxt = RESP;
            WRITE: begin
                // A reset landing in the work cycle must not leave a stray write behind.
                bus.tlb_we = resetn;
                state_nxt  = RESP;
            end
            INV: begin
                bus.mem_stall        = 1'b1;
                bus.tlb_invtlb_valid = resetn && (inv_op_q <= 5'd6);
                state_nxt            = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fill_cnt   <= '0;
            op_q       <= '0;
            err_q      <= 1'b0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
            ne_q       <= 1'b0;
            ps_q       <= '0;
            index_q    <= '0;
            vppn_q     <= '0;
            elo0_q     <= '0;
            elo1_q     <= '0;
            asid_q     <= '0;
            fill_q     <= '0;
        end else begin
            fill_cnt <= fill_cnt + 1'b1;
            if (accept) begin
                op_q       <= bus.op_code;
                err_q      <= (bus.op_code > OP_INV) || (bus.op_code == OP_INV && bus.inv_op > 5'd6);
                inv_op_q   <= bus.inv_op;
                inv_asid_q <= bus.inv_asid;
                inv_vppn_q <= bus.inv_vppn;
                ne_q       <= bus.csr_tlbidx[31];
                ps_q       <= bus.csr_tlbidx[29:24];
                index_q    <= bus.csr_tlbidx[IW-1:0];
                vppn_q     <= bus.csr_tlbehi[31:13];
                elo0_q     <= bus.csr_tlbelo0[27:0];
                elo1_q     <= bus.csr_tlbelo1[27:0];
                asid_q     <= bus.csr_asid;
                fill_q     <= fill_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            res_tlbidx_q  <= '0;
            res_tlbehi_q  <= '0;
            res_tlbelo0_q <= '0;
            res_tlbelo1_q <= '0;
            res_asid_q    <= '0;
        end else if (state == SRCH) begin
            if (bus.tlb_s1_found) begin
                res_tlbidx_q <= {2'b00, ps_q, {(24-IW){1'b0}}, bus.tlb_s1_index};
            end else begin
                res_tlbidx_q <= {2'b10, ps_q, 24'b0};
            end
        end else if (state == RD) begin
            if (bus.tlb_r_e) begin
                res_tlbidx_q  <= {2'b00, bus.tlb_r_ps, {(24-IW){1'b0}}, index_q};
                res_tlbehi_q  <= {bus.tlb_r_vppn, 13'b0};
                res_tlbelo0_q <= {4'b0, bus.tlb_r_ppn0, 1'b0, bus.tlb_r_g, bus.tlb_r_mat0,
                                  bus.tlb_r_plv0, bus.tlb_r_d0, bus.tlb_r_v0};
                res_tlbelo1_q <= {4'b0, bus.tlb_r_ppn1, 1'b0, bus.tlb_r_g, bus.tlb_r_mat1,
                                  bus.tlb_r_plv1, bus.tlb_r_d1, bus.tlb_r_v1};
                res_asid_q    <= bus.tlb_r_asid;
            end else begin
                res_tlbidx_q  <= {2'b10, 6'b0, {(24-IW){1'b0}}, index_q};
                res_tlbehi_q  <= '0;
                res_tlbelo0_q <= '0;
                res_tlbelo1_q <= '0;
                res_asid_q    <= '0;
            end
        end
    end

    // Port 1 belongs to MEM except during our own search/invalidate cycle.
    assign bus.tlb_s1_vppn     = (state == SRCH) ? vppn_q : (state == INV) ? inv_vppn_q : bus.mem_vppn;
    assign bus.tlb_s1_va_bit12 = (state == SRCH || state == INV) ? 1'b0 : bus.mem_va_bit12;
    assign bus.tlb_s1_asid     = (state == SRCH) ? asid_q : (state == INV) ? inv_asid_q : bus.mem_asid;

    assign bus.tlb_invtlb_op = inv_op_q;
    assign bus.tlb_r_index   = index_q;

    assign bus.tlb_w_index = (op_q == OP_FILL) ? fill_q : index_q;
    assign bus.tlb_w_e     = ~ne_q;
    assign bus.tlb_w_ps    = ps_q;
    assign bus.tlb_w_vppn  = vppn_q;
    assign bus.tlb_w_asid  = asid_q;
    assign bus.tlb_w_g     = elo0_q[6] & elo1_q[6];
    assign bus.tlb_w_ppn0  = elo0_q[27:8];
    assign bus.tlb_w_ppn1  = elo1_q[27:8];
    assign bus.tlb_w_plv0  = elo0_q[3:2];
    assign bus.tlb_w_plv1  = elo1_q[3:2];
    assign bus.tlb_w_mat0  = elo0_q[5:4];
    assign bus.tlb_w_mat1  = elo1_q[5:4];
    assign bus.tlb_w_d0    = elo0_q[1];
    assign bus.tlb_w_d1    = elo1_q[1];
    assign bus.tlb_w_v0    = elo0_q[0];
    assign bus.tlb_w_v1    = elo1_q[0];

    assign bus.rsp_op      = op_q;
    assign bus.res_tlbidx  = res_tlbidx_q;
    assign bus.res_tlbehi  = res_tlbehi_q;
    assign bus.res_tlbelo0 = res_tlbelo0_q;
    assign bus.res_tlbelo1 = res_tlbelo1_q;
    assign bus.res_asid    = res_asid_q;

    // CSR bits that carry no TLB state.
    logic unused_bits;
    assign unused_bits = ^{bus.csr_tlbidx[30], bus.csr_tlbidx[23:IW], bus.csr_tlbehi[12:0],
                           bus.csr_tlbelo0[31:28], bus.csr_tlbelo1[31:28], elo0_q[7], elo1_q[7]};
endmodule
